fifo_stream_reader: RTL and testbench
=====================================

# fifo_stream_reader

Read-side adapter for the synchronous FIFO (`BUS_WIDTH`/`FIFO_DEPTH` style FIFO with `RD_EN`, registered `DATA_OUT`, `EMPTY`/`FULL` flags and write-priority arbitration). It issues FIFO reads, absorbs the FIFO's one-cycle read latency in a 3-entry buffer, and presents the data as a valid/ready stream with full throughput and no combinational path from `M_READY` to `FIFO_RD_EN`. It sits between the FIFO read port and any downstream stream consumer.

## Interface
- `BUS_WIDTH`, default 8: data width; must match the FIFO.
- `CLK`  in  1  rising-edge clock; same clock as the FIFO.
- `RSTn`  in  1  asynchronous, active-low reset.
- `FIFO_EMPTY`  in  1  FIFO `EMPTY` flag.
- `FIFO_FULL`  in  1  FIFO `FULL` flag.
- `FIFO_WR_EN`  in  1  snoop of the FIFO write enable.
- `FIFO_DATA`  in  `BUS_WIDTH`  FIFO `DATA_OUT`.
- `FIFO_RD_EN`  out  1  FIFO read enable.
- `FLUSH`  in  1  synchronous discard of all buffered and in-flight words.
- `M_VALID`  out  1  stream valid.
- `M_READY`  in  1  stream ready.
- `M_DATA`  out  `BUS_WIDTH`  stream data.
- `BEAT_CNT`  out  16  delivered-beat count. Present only with `FIFO_RD_BEAT_CNT_EN`.

## Operation
- FIFO contract:
  - A write is accepted when `FIFO_WR_EN && !FIFO_FULL`. An accepted write blocks any read in the same cycle.
  - A read is accepted when `FIFO_RD_EN && !FIFO_EMPTY` and no write is accepted.
  - `FIFO_DATA` holds the read word in the cycle after acceptance.
- State:
  - `occ` (0..3): buffered words.
  - `inflight` (0/1): a read was accepted at the last edge.
  - `head`/`tail`: 2-bit pointers that wrap 2→0.
- Read issue: `FIFO_RD_EN = RSTn && !FLUSH && !FIFO_EMPTY && !(FIFO_WR_EN && !FIFO_FULL) && (occ + inflight <= 2)`. This depends only on registered state and FIFO inputs.
- Every asserted `FIFO_RD_EN` is an accepted read. `inflight` is set to `FIFO_RD_EN` at each edge.
- Capture: when `inflight` is set and `FLUSH` is low, write `FIFO_DATA` to `buf[tail]` at the edge and advance `tail`.
- Pop: on `M_VALID && M_READY`, advance `head`.
- Occupancy: capture and pop in the same cycle leave `occ` unchanged. `occ` never exceeds 3 by construction.
- `M_VALID = (occ != 0)`. `M_DATA = buf[head]`, held stable while `M_VALID && !M_READY`.
- FLUSH at an edge:
  - `occ`, `head`, `tail` and `inflight` go to 0.
  - A word in flight is dropped.
  - The FIFO's own contents are untouched.

## Timing
- Reset values: `M_VALID` 0, `M_DATA` 0, `FIFO_RD_EN` 0 (forced while `RSTn` low), `occ`/`inflight`/pointers 0, `BEAT_CNT` 0.
- First-word latency: `FIFO_RD_EN` in cycle t, `inflight` in t+1, `M_VALID` in t+2.
- Throughput: one word per cycle sustained while the FIFO is non-empty, no write collides, and `M_READY` is high.
- Backpressure: with `M_READY` low, at most 3 words are pulled. Reads stop once `occ + inflight = 3`.
- FLUSH: `M_VALID` is 0 in the cycle after `FLUSH` is sampled high. Reads resume in the first cycle with `FLUSH` low.
- Reset asserted mid-stream: all state clears immediately. Buffered and in-flight words are lost.

## Configuration
- `FIFO_RD_BEAT_CNT_EN` defined:
  - `BEAT_CNT` is added.
  - It increments on each `M_VALID && M_READY`, wraps 0xFFFF→0, is cleared only by reset, and is unaffected by `FLUSH`.
- `FIFO_RD_BEAT_CNT_EN` undefined: the port and counter are absent; behaviour is otherwise identical.

## Structure
- Package `fifo_rd_pkg`:
  - `BUF_DEPTH` = 3.
  - Pointer width (2) and occupancy width (2).
  - Pointer-increment-with-wrap function.
- Sub-module `fifo_rd_skid_buf`: 3-entry circular buffer with push/pop/flush, `occ`, head data.
- The top level holds issue logic, `inflight`, and the optional counter.

## Test plan
- Reset, FIFO loaded with 0x11, 0x22, 0x33, 0x44, `M_READY`=1 → `M_DATA` 0x11..0x44 on 4 consecutive cycles; first `M_VALID` two cycles after the first `FIFO_RD_EN`.
- 5 words in FIFO, `M_READY`=0 → exactly 3 `FIFO_RD_EN` pulses, `M_DATA`=first word held stable; raise `M_READY` → all 5 words in order with no gaps.
- FIFO non-empty with `FIFO_WR_EN`=1, `FIFO_FULL`=0 for 3 cycles → `FIFO_RD_EN`=0 in those cycles; output sequence has no loss or duplicate.
- Stream 0x00..0x09 with `M_READY` toggling 1,0,1,0 → order preserved across multiple pointer wraps; `occ` never exceeds 3.
- `FLUSH` pulsed with `occ`=2 and `inflight`=1 → `M_VALID`=0 next cycle; none of the 3 words appear; the next FIFO word is delivered normally.
- `RSTn` low mid-stream → `M_VALID` and `FIFO_RD_EN` are 0 immediately. With `FIFO_RD_BEAT_CNT_EN`: `BEAT_CNT`=0 after reset, and 65536 beats wrap it back to 0.

Source files
------------

// File: rtl/fifo_rd_pkg.sv
// fifo_rd_pkg: shared sizes, types and pointer helper for the FIFO stream
// reader. The skid buffer holds three words: enough to cover the FIFO's
// one-cycle read latency while the read enable stays fully registered.
package fifo_rd_pkg;

   localparam int BUF_DEPTH = 3;
   localparam int PTR_W     = 2;
   localparam int OCC_W     = 2;

   typedef logic [PTR_W-1:0] ptr_t;
   typedef logic [OCC_W-1:0] occ_t;

   // Advance a buffer pointer, wrapping from the last entry back to 0.
   function automatic ptr_t ptr_inc(input ptr_t p);
      ptr_t nxt;
      if (p == ptr_t'(BUF_DEPTH - 1)) begin
         nxt = '0;
      end else begin
         nxt = p + ptr_t'(1);
      end
      return nxt;
   endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// fifo_stream_reader_if: valid/ready stream carrying FIFO words downstream.
// master drives valid/data, slave drives ready.
interface fifo_stream_reader_if #(
   parameter int BUS_WIDTH = 8
);
   logic                 M_VALID;
   logic                 M_READY;
   logic [BUS_WIDTH-1:0] M_DATA;

   modport master (output M_VALID, output M_DATA, input M_READY);
   modport slave  (input M_VALID, input M_DATA, output M_READY);
endinterface

// File: rtl/fifo_rd_skid_buf.sv
// fifo_rd_skid_buf: three-entry circular buffer that absorbs words returning
// from the FIFO. push/pop may coincide; flush empties it in one edge.
module fifo_rd_skid_buf
   import fifo_rd_pkg::*;
#(
   parameter int BUS_WIDTH = 8
) (
   input  logic                 CLK,
   input  logic                 RSTn,
   input  logic                 push,
   input  logic [BUS_WIDTH-1:0] push_data,
   input  logic                 pop,
   input  logic                 flush,
   output occ_t                 occ,
   output logic [BUS_WIDTH-1:0] head_data
);

   logic [BUS_WIDTH-1:0] mem [BUF_DEPTH];
   ptr_t                 head;
   ptr_t                 tail;

   // Pointer and occupancy bookkeeping; a flush drops everything buffered.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         head <= '0;
         tail <= '0;
         occ  <= '0;
      end else if (flush) begin
         head <= '0;
         tail <= '0;
         occ  <= '0;
      end else begin
         if (push) tail <= ptr_inc(tail);
         if (pop)  head <= ptr_inc(head);
         case ({push, pop})
            2'b10:   occ <= occ + occ_t'(1);
            2'b01:   occ <= occ - occ_t'(1);
            default: occ <= occ;
         endcase
      end
   end

   // Word storage; cleared on reset so the stream data starts at zero.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
      end else if (push && !flush) begin
         mem[tail] <= push_data;
      end
   end

   assign head_data = mem[head];

endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: issues FIFO reads and presents the returned words as a
// valid/ready stream at full throughput. FIFO_RD_EN depends only on registered
// state and the FIFO flags, never on M_READY.
// Optional build macro: FIFO_RD_BEAT_CNT_EN adds the 16-bit BEAT_CNT output.
module fifo_stream_reader
   import fifo_rd_pkg::*;
#(
   parameter int BUS_WIDTH = 8
) (
   input  logic                 CLK,
   input  logic                 RSTn,
   input  logic                 FIFO_EMPTY,
   input  logic                 FIFO_FULL,
   input  logic                 FIFO_WR_EN,
   input  logic [BUS_WIDTH-1:0] FIFO_DATA,
   output logic                 FIFO_RD_EN,
   input  logic                 FLUSH,
   fifo_stream_reader_if.master m
`ifdef FIFO_RD_BEAT_CNT_EN
   ,
   output logic [15:0]          BEAT_CNT
`endif
);

   occ_t           occ;
   logic           inflight;
   logic [OCC_W:0] committed;
   logic           write_acc;
   logic           pop;

   assign write_acc = FIFO_WR_EN && !FIFO_FULL;
   assign committed = {1'b0, occ} + {{OCC_W{1'b0}}, inflight};
   assign pop       = m.M_VALID && m.M_READY;
   assign m.M_VALID = (occ != '0);

   // Read only when the word coming back is guaranteed a free buffer slot and
   // the FIFO will actually serve it (a colliding write wins arbitration).
   always_comb begin
      FIFO_RD_EN = RSTn && !FLUSH && !FIFO_EMPTY && !write_acc &&
                   (committed <= (OCC_W+1)'(BUF_DEPTH - 1));
   end

   // Every issued read is accepted, so the returning word is due next cycle.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         inflight <= 1'b0;
      end else begin
         inflight <= FIFO_RD_EN;
      end
   end

   fifo_rd_skid_buf #(
      .BUS_WIDTH (BUS_WIDTH)
   ) u_skid (
      .CLK       (CLK),
      .RSTn      (RSTn),
      .push      (inflight),
      .push_data (FIFO_DATA),
      .pop       (pop),
      .flush     (FLUSH),
      .occ       (occ),
      .head_data (m.M_DATA)
   );

`ifdef FIFO_RD_BEAT_CNT_EN
   // Delivered-beat counter; wraps naturally and ignores FLUSH.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         BEAT_CNT <= '0;
      end else if (pop) begin
         BEAT_CNT <= BEAT_CNT + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: bench with a queue-based FIFO model and a
// scoreboard of words read from the FIFO but not yet delivered downstream.
`timescale 1ns/1ps
module tb_fifo_stream_reader;

   localparam int BW         = 8;
   localparam int FIFO_DEPTH = 8;

   logic          CLK        = 1'b0;
   logic          RSTn       = 1'b0;
   logic          FIFO_EMPTY = 1'b1;
   logic          FIFO_FULL  = 1'b0;
   logic          FIFO_WR_EN = 1'b0;
   logic          FLUSH      = 1'b0;
   logic [BW-1:0] FIFO_DATA  = '0;
   logic [BW-1:0] wr_data    = '0;
   logic          FIFO_RD_EN;
`ifdef FIFO_RD_BEAT_CNT_EN
   logic [15:0]   BEAT_CNT;
`endif

   fifo_stream_reader_if #(.BUS_WIDTH(BW)) sif ();

   fifo_stream_reader #(.BUS_WIDTH(BW)) dut (
      .CLK        (CLK),
      .RSTn       (RSTn),
      .FIFO_EMPTY (FIFO_EMPTY),
      .FIFO_FULL  (FIFO_FULL),
      .FIFO_WR_EN (FIFO_WR_EN),
      .FIFO_DATA  (FIFO_DATA),
      .FIFO_RD_EN (FIFO_RD_EN),
      .FLUSH      (FLUSH),
      .m          (sif.master)
`ifdef FIFO_RD_BEAT_CNT_EN
      ,
      .BEAT_CNT   (BEAT_CNT)
`endif
   );

   always #5 CLK = ~CLK;

   logic [BW-1:0] fifo_q [$];
   logic [BW-1:0] exp_q  [$];
   bit            pend;
   logic [15:0]   beats;
   int            beat_total;
   int            checks   = 0;
   int            failures = 0;
   int            rd_cnt   = 0;
   int            hs_cnt   = 0;
   int            cyc      = 0;
   int            first_rd = -1;
   int            first_vld = -1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor/scoreboard: samples at the falling edge what the next rising edge commits.
   always @(negedge CLK) begin
      bit wr_acc, rd_exp, rd_acc, hs;
      cyc++;
      if (!RSTn) begin
         chk("rst_m_valid", 32'(sif.M_VALID), 32'd0);
         chk("rst_rd_en", 32'(FIFO_RD_EN), 32'd0);
         chk("rst_m_data", 32'(sif.M_DATA), 32'd0);
`ifdef FIFO_RD_BEAT_CNT_EN
         chk("rst_beat_cnt", 32'(BEAT_CNT), 32'd0);
`endif
         exp_q.delete();
         pend       = 1'b0;
         beats      = '0;
         beat_total = 0;
      end else begin
         wr_acc = FIFO_WR_EN && !FIFO_FULL;
         rd_exp = !FLUSH && !FIFO_EMPTY && !wr_acc && (exp_q.size() <= 2);
         chk("rd_issue", 32'(FIFO_RD_EN), 32'(rd_exp));
         chk("m_valid", 32'(sif.M_VALID), 32'(exp_q.size() > int'(pend)));
`ifdef FIFO_RD_BEAT_CNT_EN
         chk("beat_cnt", 32'(BEAT_CNT), 32'(beats));
`endif
         if (FIFO_RD_EN && first_rd < 0) first_rd = cyc;
         if (sif.M_VALID && first_vld < 0) first_vld = cyc;
         rd_acc = FIFO_RD_EN && !FIFO_EMPTY && !wr_acc;
         hs     = sif.M_VALID && sif.M_READY;
         if (hs) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL spurious_beat actual=0x%0h required=none at %0t", sif.M_DATA, $time);
            end else begin
               chk("m_data", 32'(sif.M_DATA), 32'(exp_q.pop_front()));
            end
            beats++;
            beat_total++;
            hs_cnt++;
         end
         if (FLUSH) exp_q.delete();
         if (rd_acc) begin
            exp_q.push_back(fifo_q[0]);
            rd_cnt++;
         end
         pend = rd_acc;
         chk("occ_bound", 32'(exp_q.size() <= 3), 32'd1);
      end
   end

   // One clock of the FIFO model: accepted write/read applied after the edge.
   task automatic cycle();
      bit wr_acc, rd_acc;
      @(negedge CLK);
      wr_acc = FIFO_WR_EN && !FIFO_FULL;
      rd_acc = FIFO_RD_EN && !FIFO_EMPTY && !wr_acc;
      @(posedge CLK);
      #1;
      if (wr_acc) fifo_q.push_back(wr_data);
      if (rd_acc) FIFO_DATA = fifo_q.pop_front();
      FIFO_EMPTY = (fifo_q.size() == 0);
      FIFO_FULL  = (fifo_q.size() >= FIFO_DEPTH);
   endtask

   task automatic load(input logic [BW-1:0] v);
      fifo_q.push_back(v);
      FIFO_EMPTY = 1'b0;
      FIFO_FULL  = (fifo_q.size() >= FIFO_DEPTH);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic drain_and_check(input string name);
      FIFO_WR_EN  = 1'b0;
      FLUSH       = 1'b0;
      sif.M_READY = 1'b1;
      run(20);
      chk({name, "_fifo_empty"}, 32'(fifo_q.size()), 32'd0);
      chk({name, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      sif.M_READY = 1'b1;
      // Reset with a loaded FIFO: no reads may issue while RSTn is low.
      run(1);
      load(8'h11); load(8'h22); load(8'h33); load(8'h44);
      run(2);
      RSTn      = 1'b1;
      first_rd  = -1;
      first_vld = -1;
      hs_cnt    = 0;
      run(6);
      chk("first_word_latency", 32'(first_vld - first_rd), 32'd2);
      chk("burst_beats", 32'(hs_cnt), 32'd4);
      drain_and_check("burst");

      // Backpressure: three words pulled, head word held.
      sif.M_READY = 1'b0;
      for (int i = 0; i < 5; i++) load(8'hA0 + 8'(i));
      rd_cnt = 0;
      run(8);
      chk("bp_reads", 32'(rd_cnt), 32'd3);
      chk("bp_hold_valid", 32'(sif.M_VALID), 32'd1);
      chk("bp_hold_data", 32'(sif.M_DATA), 32'hA0);
      sif.M_READY = 1'b1;
      hs_cnt = 0;
      run(5);
      chk("bp_release_beats", 32'(hs_cnt), 32'd5);
      drain_and_check("bp");

      // Colliding writes block reads for three cycles.
      load(8'h51); load(8'h52); load(8'h53);
      run(1);
      FIFO_WR_EN = 1'b1;
      rd_cnt = 0;
      for (int i = 0; i < 3; i++) begin
         wr_data = 8'(60 + i);
         cycle();
      end
      chk("collide_no_reads", 32'(rd_cnt), 32'd0);
      drain_and_check("collide");

      // 0x00..0x09 with ready toggling every cycle.
      for (int i = 0; i < 10; i++) load(8'(i));
      hs_cnt = 0;
      for (int i = 0; i < 30; i++) begin
         sif.M_READY = (i % 2 == 0);
         cycle();
      end
      chk("toggle_beats", 32'(hs_cnt), 32'd10);
      drain_and_check("toggle");

      // Flush with two buffered words and one in flight.
      sif.M_READY = 1'b0;
      for (int i = 0; i < 5; i++) load(8'hC0 + 8'(i));
      run(3);
      chk("pre_flush_fill", 32'(exp_q.size()), 32'd3);
      FLUSH = 1'b1;
      cycle();
      FLUSH = 1'b0;
      chk("post_flush_valid", 32'(sif.M_VALID), 32'd0);
      sif.M_READY = 1'b1;
      hs_cnt = 0;
      run(6);
      chk("post_flush_beats", 32'(hs_cnt), 32'd2);
      drain_and_check("flush");

      // Randomized traffic.
      for (int i = 0; i < 1500; i++) begin
         FIFO_WR_EN  = ($urandom_range(0, 3) == 0);
         wr_data     = 8'($urandom);
         sif.M_READY = ($urandom_range(0, 4) < 3);
         FLUSH       = ($urandom_range(0, 31) == 0);
         cycle();
      end
      drain_and_check("random");

      // Reset mid-stream.
      for (int i = 0; i < 6; i++) load(8'hE0 + 8'(i));
      run(3);
      RSTn = 1'b0;
      #1;
      chk("midrst_valid", 32'(sif.M_VALID), 32'd0);
      chk("midrst_rd_en", 32'(FIFO_RD_EN), 32'd0);
      run(2);
      RSTn = 1'b1;
      drain_and_check("midrst");

`ifdef FIFO_RD_BEAT_CNT_EN
      // Counter wrap after 65536 beats from reset.
      RSTn = 1'b0;
      run(2);
      RSTn = 1'b1;
      sif.M_READY = 1'b1;
      for (int i = 0; i < 70000; i++) begin
         if (fifo_q.size() < 4) load(8'($urandom));
         cycle();
         if (beat_total >= 65536) break;
      end
      chk("wrap_beats", 32'(beat_total), 32'd65536);
      chk("wrap_beat_cnt", 32'(BEAT_CNT), 32'd0);
      drain_and_check("wrap");
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
